// File: rtl/strand_driver_multi.sv
// strand_driver_multi: streams pixel words to a one-wire (WS2811) or clocked (WS2801) LED strand.
// Optional byte reordering on load is enabled by defining STRAND_DRIVER_COLOR_ORDER_EN.
module strand_driver_multi #(
    parameter int BITS_PER_PIXEL     = 24,
    parameter int STRAND_PARAM_WIDTH = 16,
    parameter int TIMER_WIDTH        = 16,
    parameter int MEM_LATENCY        = 1,
    parameter int T0H                = 50,
    parameter int T0L                = 200,
    parameter int T1H                = 120,
    parameter int T1L                = 130,
    parameter int TCLKDIV2           = 10,
    parameter int TRESET             = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ws2811_mode,
    input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
    input  logic                          start_frame,
    output logic [STRAND_PARAM_WIDTH-1:0] current_idx,
    input  logic [BITS_PER_PIXEL-1:0]     mem_data,
    output logic                          busy,
    output logic                          done,
    output logic                          strand_clk,
    output logic                          strand_data
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
    ,
    input  logic [2:0]                    color_order
`endif
);
    localparam int BIT_W = $clog2(BITS_PER_PIXEL);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);
    localparam logic [TIMER_WIDTH-1:0] T0H_C    = TIMER_WIDTH'(T0H - 1);
    localparam logic [TIMER_WIDTH-1:0] T0L_C    = TIMER_WIDTH'(T0L - 1);
    localparam logic [TIMER_WIDTH-1:0] T1H_C    = TIMER_WIDTH'(T1H - 1);
    localparam logic [TIMER_WIDTH-1:0] T1L_C    = TIMER_WIDTH'(T1L - 1);
    localparam logic [TIMER_WIDTH-1:0] TCLK_C   = TIMER_WIDTH'(TCLKDIV2 - 1);
    localparam logic [TIMER_WIDTH-1:0] TRESET_C = TIMER_WIDTH'(TRESET - 1);

    typedef enum logic [2:0] {IDLE, FETCH, PH1, PH2, LATCH} state_t;

    state_t                          state_q, state_d;
    logic [TIMER_WIDTH-1:0]          timer_q, timer_d;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [BITS_PER_PIXEL-1:0]       shift_q, shift_d, pref_q, pref_d, load_word;
    logic [STRAND_PARAM_WIDTH-1:0]   idx_q, idx_d, len_q, len_d;
    logic [2:0]                      lat_q, lat_d;
    logic                            mode_q, mode_d, pf_pend_q, pf_pend_d, load;
    logic                            busy_q, busy_d, done_q, done_d;
    logic                            sclk_q, sclk_d, sdata_q, sdata_d;

    function automatic logic [TIMER_WIDTH-1:0] ph1_len(input logic one_wire, input logic b);
        if (!one_wire) return TCLK_C;
        return b ? T1H_C : T0H_C;
    endfunction

    function automatic logic [TIMER_WIDTH-1:0] ph2_len(input logic one_wire, input logic b);
        if (!one_wire) return TCLK_C;
        return b ? T1L_C : T0L_C;
    endfunction

`ifdef STRAND_DRIVER_COLOR_ORDER_EN
    logic [2:0] color_q, color_d;

    // Byte 2 is red, byte 1 green, byte 0 blue; any upper byte passes through.
    function automatic logic [BITS_PER_PIXEL-1:0] reorder(input logic [BITS_PER_PIXEL-1:0] w,
                                                          input logic [2:0] sel);
        logic [BITS_PER_PIXEL-1:0] o;
        o = w;
        case (sel)
            3'd1:    o[23:0] = {w[15:8], w[23:16], w[7:0]};
            3'd2:    o[23:0] = {w[7:0], w[23:16], w[15:8]};
            3'd3:    o[23:0] = {w[23:16], w[7:0], w[15:8]};
            3'd4:    o[23:0] = {w[15:8], w[7:0], w[23:16]};
            3'd5:    o[23:0] = {w[7:0], w[15:8], w[23:16]};
            default: o = w;
        endcase
        return o;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pref_d    = pref_q;
        idx_d     = idx_q;
        len_d     = len_q;
        lat_d     = lat_q;
        mode_d    = mode_q;
        pf_pend_d = pf_pend_q;
        load      = 1'b0;
        load_word = mem_data;
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
        color_d   = color_q;
`endif

        // Prefetch capture runs underneath the bit phases, MEM_LATENCY cycles after each index move.
        if (pf_pend_q) begin
            if (lat_q == 3'd0) begin
                pref_d    = mem_data;
                pf_pend_d = 1'b0;
            end else begin
                lat_d = lat_q - 3'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    mode_d    = ws2811_mode;
                    len_d     = strand_length;
                    idx_d     = '0;
                    pf_pend_d = 1'b0;
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
                    color_d   = color_order;
`endif
                    if (strand_length == '0) begin
                        state_d = LATCH;
                        timer_d = TRESET_C;
                    end else begin
                        state_d = FETCH;
                        lat_d   = LAT;
                    end
                end
            end
            FETCH: begin
                if (lat_q == 3'd0) load = 1'b1;
                else lat_d = lat_q - 3'd1;
            end
            PH1: begin
                if (timer_q == '0) begin
                    state_d = PH2;
                    timer_d = ph2_len(mode_q, shift_q[BITS_PER_PIXEL-1]);
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
            PH2: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end else if (bit_q != '0) begin
                    bit_d   = bit_q - BIT_W'(1);
                    shift_d = shift_q << 1;
                    state_d = PH1;
                    timer_d = ph1_len(mode_q, shift_d[BITS_PER_PIXEL-1]);
                end else if (idx_q < len_q) begin
                    load      = 1'b1;
                    load_word = pref_q;
                end else begin
                    state_d = LATCH;
                    timer_d = TRESET_C;
                end
            end
            LATCH: begin
                if (timer_q == '0) state_d = IDLE;
                else timer_d = timer_q - TIMER_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase

        // A load starts the next pixel in PH1 and points the RAM at the one after it.
        if (load) begin
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
            shift_d = reorder(load_word, color_d);
`else
            shift_d = load_word;
`endif
            bit_d     = BIT_MSB;
            state_d   = PH1;
            timer_d   = ph1_len(mode_d, shift_d[BITS_PER_PIXEL-1]);
            lat_d     = LAT;
            pf_pend_d = 1'b1;
            if (idx_q < len_q) idx_d = idx_q + STRAND_PARAM_WIDTH'(1);
        end

        sdata_d = 1'b0;
        sclk_d  = 1'b0;
        if (state_d == PH1) begin
            sdata_d = mode_d | shift_d[BITS_PER_PIXEL-1];
        end else if (state_d == PH2) begin
            sdata_d = ~mode_d & shift_d[BITS_PER_PIXEL-1];
            sclk_d  = ~mode_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == LATCH) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            pref_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            lat_q     <= '0;
            mode_q    <= 1'b0;
            pf_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
            color_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            pref_q    <= pref_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            lat_q     <= lat_d;
            mode_q    <= mode_d;
            pf_pend_q <= pf_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
            color_q   <= color_d;
`endif
        end
    end

    assign current_idx = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign strand_clk  = sclk_q;
    assign strand_data = sdata_q;

endmodule

// File: tb/tb_strand_driver_multi.sv
// Testbench for strand_driver_multi: compares every output cycle of each frame with a waveform
// built directly from the strand timing rules; color checks only when STRAND_DRIVER_COLOR_ORDER_EN is set.
module tb_strand_driver_multi;
    localparam int BPP    = 24;
    localparam int L      = 2;
    localparam int T0H    = 3;
    localparam int T0L    = 6;
    localparam int T1H    = 6;
    localparam int T1L    = 3;
    localparam int TCD2   = 2;
    localparam int TRESET = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ws2811_mode = 1'b0;
    logic [15:0]     strand_length = '0;
    logic            start_frame = 1'b0;
    logic [15:0]     current_idx;
    logic [BPP-1:0]  mem_data;
    logic            busy, done, strand_clk, strand_data;
    logic [2:0]      color_sel = 3'd0;

    logic [BPP-1:0]  ram [0:15];
    logic [BPP-1:0]  pipe [0:L-1];

    logic [3:0]      exp_q[$];
    logic [3:0]      obs_q[$];
    int              exp_idx[$];
    int              obs_idx[$];
    logic            timed_out;
    int              first_diff;
    int              total = 0;
    int              bad = 0;

    strand_driver_multi #(
        .BITS_PER_PIXEL(BPP), .STRAND_PARAM_WIDTH(16), .TIMER_WIDTH(16), .MEM_LATENCY(L),
        .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TCLKDIV2(TCD2), .TRESET(TRESET)
    ) dut (
        .clk(clk), .rst(rst), .ws2811_mode(ws2811_mode), .strand_length(strand_length),
        .start_frame(start_frame), .current_idx(current_idx), .mem_data(mem_data),
        .busy(busy), .done(done), .strand_clk(strand_clk), .strand_data(strand_data)
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
        , .color_order(color_sel)
`endif
    );

    always #5 clk = ~clk;

    // Pixel RAM with a read pipeline of L cycles.
    always @(posedge clk) begin
        pipe[0] <= ram[current_idx[3:0]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data = pipe[L-1];

`ifdef STRAND_DRIVER_COLOR_ORDER_EN
    function automatic logic [BPP-1:0] model_order(input logic [BPP-1:0] w, input logic [2:0] sel);
        logic [7:0] r, g, b;
        r = w[23:16];
        g = w[15:8];
        b = w[7:0];
        case (sel)
            3'd1:    return {g, r, b};
            3'd2:    return {b, r, g};
            3'd3:    return {r, b, g};
            3'd4:    return {g, b, r};
            3'd5:    return {b, g, r};
            default: return w;
        endcase
    endfunction
`else
    function automatic logic [BPP-1:0] model_order(input logic [BPP-1:0] w);
        return w;
    endfunction
`endif

    // Expected {busy, done, strand_clk, strand_data} per cycle, starting the cycle after acceptance.
    task automatic build_expected(input logic mode, input int len);
        logic [BPP-1:0] w;
        exp_q.delete();
        exp_idx.delete();
        if (len > 0) repeat (L + 1) exp_q.push_back(4'b1000);
        for (int p = 0; p < len; p++) begin
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
            w = model_order(ram[p], color_sel);
`else
            w = model_order(ram[p]);
`endif
            for (int b = BPP - 1; b >= 0; b--) begin
                if (mode) begin
                    repeat (w[b] ? T1H : T0H) exp_q.push_back(4'b1001);
                    repeat (w[b] ? T1L : T0L) exp_q.push_back(4'b1000);
                end else begin
                    repeat (TCD2) exp_q.push_back({3'b100, w[b]});
                    repeat (TCD2) exp_q.push_back({3'b101, w[b]});
                end
            end
        end
        repeat (TRESET) exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        for (int i = 0; i <= len; i++) exp_idx.push_back(i);
    endtask

    task automatic kick(input logic mode, input int len);
        @(negedge clk);
        ws2811_mode   = mode;
        strand_length = 16'(len);
        start_frame   = 1'b1;
        @(negedge clk);
        start_frame   = 1'b0;
    endtask

    // Records outputs from the current negedge until done (inclusive) or the cycle limit.
    task automatic capture(input int limit, input int pulse_at, input int hold_from);
        obs_q.delete();
        obs_idx.delete();
        timed_out = 1'b1;
        for (int c = 0; c < limit; c++) begin
            obs_q.push_back({busy, done, strand_clk, strand_data});
            if (obs_idx.size() == 0 || obs_idx[$] != int'(current_idx))
                obs_idx.push_back(int'(current_idx));
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            start_frame = (c == pulse_at) || (hold_from >= 0 && c >= hold_from);
            @(negedge clk);
        end
    endtask

    function automatic int wave_diff();
        int n = 0;
        first_diff = -1;
        if (timed_out || obs_q.size() != exp_q.size()) n++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin
                n++;
                if (first_diff < 0) first_diff = i;
            end
        return n;
    endfunction

    function automatic int idx_diff();
        int n = 0;
        if (obs_idx.size() != exp_idx.size()) n++;
        for (int i = 0; i < obs_idx.size() && i < exp_idx.size(); i++)
            if (obs_idx[i] != exp_idx[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset done: got %b want 0", done); end
        total++; if (strand_clk !== 1'b0) begin bad++; $display("[TB] FAIL reset strand_clk: got %b want 0", strand_clk); end
        total++; if (strand_data !== 1'b0) begin bad++; $display("[TB] FAIL reset strand_data: got %b want 0", strand_data); end
        total++; if (current_idx !== 16'd0) begin bad++; $display("[TB] FAIL reset current_idx: got %0d want 0", current_idx); end
        rst = 1'b0;
    endtask

    task automatic test_one_wire();
        int n, bw;
        ram[0] = 24'h800001;
        build_expected(1'b1, 1);
        kick(1'b1, 1);
        capture(exp_q.size() + 50, -1, -1);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL one_wire waveform: %0d diffs first at %0d, got %0d cycles want %0d", n, first_diff, obs_q.size(), exp_q.size()); end
        n = idx_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL one_wire idx sequence: got %0d values want %0d", obs_idx.size(), exp_idx.size()); end
        bw = 0;
        foreach (obs_q[i]) if (obs_q[i][3]) bw++;
        total++; if (bw != (L + 1) + BPP * (T1H + T1L) + TRESET) begin bad++; $display("[TB] FAIL one_wire busy width: got %0d want %0d", bw, (L + 1) + BPP * (T1H + T1L) + TRESET); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL one_wire done pulse width: got done=%b one cycle later want 0", done); end
    endtask

    task automatic test_clocked();
        int n, rises;
        ram[0] = 24'hAA5500;
        ram[1] = 24'h00FF0F;
        ram[2] = 24'hFFFFFF;
        build_expected(1'b0, 3);
        kick(1'b0, 3);
        capture(exp_q.size() + 50, -1, -1);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL clocked waveform: %0d diffs first at %0d, got %0d cycles want %0d", n, first_diff, obs_q.size(), exp_q.size()); end
        n = idx_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL clocked idx sequence: got %0d values (last %0d) want 0..3", obs_idx.size(), obs_idx.size() > 0 ? obs_idx[$] : -1); end
        rises = 0;
        for (int i = 1; i < obs_q.size(); i++) if (obs_q[i][1] && !obs_q[i-1][1]) rises++;
        total++; if (rises != 3 * BPP) begin bad++; $display("[TB] FAIL clocked rising edges: got %0d want %0d", rises, 3 * BPP); end
    endtask

    task automatic test_zero_length();
        int n;
        build_expected(1'b1, 0);
        kick(1'b1, 0);
        capture(exp_q.size() + 50, -1, -1);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL zero_length waveform: %0d diffs first at %0d, got %0d cycles want %0d", n, first_diff, obs_q.size(), exp_q.size()); end
        n = idx_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL zero_length idx: got %0d values want only 0", obs_idx.size()); end
    endtask

    task automatic test_random_frames();
        int n, len;
        logic mode;
        for (int f = 0; f < 4; f++) begin
            mode = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 4);
            for (int i = 0; i < 16; i++) ram[i] = BPP'($urandom);
            color_sel = 3'($urandom_range(0, 7));
            build_expected(mode, len);
            kick(mode, len);
            capture(exp_q.size() + 50, -1, -1);
            n = wave_diff();
            total++; if (n != 0) begin bad++; $display("[TB] FAIL random frame %0d waveform (mode=%b len=%0d): %0d diffs first at %0d", f, mode, len, n, first_diff); end
            n = idx_diff();
            total++; if (n != 0) begin bad++; $display("[TB] FAIL random frame %0d idx: got %0d values want %0d", f, obs_idx.size(), exp_idx.size()); end
        end
        color_sel = 3'd0;
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 16; i++) ram[i] = BPP'($urandom);
        build_expected(1'b0, 2);
        kick(1'b0, 2);
        capture(exp_q.size() + 50, 40, exp_q.size() - 10);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL back_to_back first frame: %0d diffs first at %0d", n, first_diff); end
        @(negedge clk);
        start_frame = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL back_to_back restart: got busy=%b done=%b want busy=1 done=0", busy, done); end
        capture(exp_q.size() + 50, -1, -1);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL back_to_back second frame: %0d diffs first at %0d", n, first_diff); end
    endtask

    task automatic test_rst_abort();
        int n, dones;
        for (int i = 0; i < 16; i++) ram[i] = BPP'($urandom);
        kick(1'b0, 3);
        repeat ((L + 1) + BPP * 2 * TCD2 + 13 * 2 * TCD2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort busy: got %b want 0", busy); end
        total++; if (current_idx !== 16'd0) begin bad++; $display("[TB] FAIL abort current_idx: got %0d want 0", current_idx); end
        total++; if (strand_clk !== 1'b0) begin bad++; $display("[TB] FAIL abort strand_clk: got %b want 0", strand_clk); end
        total++; if (strand_data !== 1'b0) begin bad++; $display("[TB] FAIL abort strand_data: got %b want 0", strand_data); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (TRESET + 100) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL abort late done pulses: got %0d want 0", dones); end
        build_expected(1'b1, 2);
        kick(1'b1, 2);
        capture(exp_q.size() + 50, -1, -1);
        n = wave_diff();
        total++; if (n != 0) begin bad++; $display("[TB] FAIL abort fresh frame: %0d diffs first at %0d", n, first_diff); end
    endtask

`ifdef STRAND_DRIVER_COLOR_ORDER_EN
    task automatic test_color_order();
        logic [BPP-1:0] word;
        color_sel = 3'd1;
        ram[0] = 24'h112233;
        kick(1'b0, 1);
        capture(BPP * 2 * TCD2 + TRESET + 60, -1, -1);
        word = '0;
        for (int i = 1; i < obs_q.size(); i++)
            if (obs_q[i][1] && !obs_q[i-1][1]) word = {word[BPP-2:0], obs_q[i][0]};
        total++; if (word !== 24'h221133) begin bad++; $display("[TB] FAIL color_order GRB word: got %h want 221133", word); end
        color_sel = 3'd0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        test_reset();
        test_one_wire();
        test_clocked();
        test_zero_length();
        test_random_frames();
        test_back_to_back();
        test_rst_abort();
`ifdef STRAND_DRIVER_COLOR_ORDER_EN
        test_color_order();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/strand_driver_multi.md
Name: strand_driver_multi

Overview:
- Parametrised successor to the single-mode pixel strand driver.
- Streams BITS_PER_PIXEL-wide words from pixel RAM to one output strand in either one-wire (WS2811-style) or clocked (WS2801-style) mode.
- Timing is set by parameters. A prefetch register keeps the bitstream gap-free across pixel boundaries.
- Ends every frame with a latch/reset period and a one-cycle done pulse. Sits between the register block / pixel RAM and the strand IOB.

Parameters:
- BITS_PER_PIXEL, 24: word width and bits shifted per pixel (24 = RGB, 32 = RGBW); must be a multiple of 8.
- STRAND_PARAM_WIDTH, 16: width of strand_length and current_idx.
- TIMER_WIDTH, 16: width of the phase down-counter.
- MEM_LATENCY, 1: clk cycles from a current_idx change to valid mem_data (1..4).
- T0H, 50: one-wire 0-bit high cycles.
- T0L, 200: one-wire 0-bit low cycles.
- T1H, 120: one-wire 1-bit high cycles.
- T1L, 130: one-wire 1-bit low cycles.
- TCLKDIV2, 10: clocked-mode half-period cycles.
- TRESET, 5000: end-of-frame latch cycles (50 us at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz nominal)
- rst  in  1  synchronous reset, active-high
- ws2811_mode  in  1  1 = one-wire, 0 = clocked; sampled at frame start
- strand_length  in  STRAND_PARAM_WIDTH  pixels per frame; sampled at frame start
- start_frame  in  1  level/pulse request; acted on only in IDLE
- current_idx  out  STRAND_PARAM_WIDTH  pixel RAM read address
- mem_data  in  BITS_PER_PIXEL  pixel RAM read data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end
- strand_clk  out  1  registered strand clock (clocked mode only)
- strand_data  out  1  registered strand data

Behaviour:
- Reset: all outputs 0, state IDLE, counters/shift/prefetch registers 0. rst mid-frame aborts immediately: outputs return to 0 the next cycle, no done pulse.
- States and transitions:
  - IDLE → FETCH on start_frame. Latches mode and length, current_idx <= 0, busy <= 1. strand_length = 0 goes to LATCH directly.
  - FETCH: waits MEM_LATENCY cycles, then loads mem_data into the shift register, sets current_idx <= 1 and enters PH1 with bit = BITS_PER_PIXEL-1.
  - PH1 → PH2 → PH1 … per bit, MSB first. Each phase lasts exactly its programmed cycle count.
  - After the PH2 of bit 0: if more pixels remain, load the shift register from prefetch with no gap cycle and go to PH1; else go to LATCH.
  - LATCH: strand_data = 0 and strand_clk = 0 for TRESET cycles, then IDLE. In the cycle LATCH exits: done = 1, busy = 0.
- Phase outputs, one-wire mode:
  - PH1: data = 1 for T1H/T0H cycles.
  - PH2: data = 0 for T1L/T0L cycles.
  - strand_clk held 0.
- Phase outputs, clocked mode:
  - PH1: data = bit, clk = 0 for TCLKDIV2.
  - PH2: data held, clk = 1 for TCLKDIV2.
- Prefetch:
  - Each shift-register load advances current_idx by 1 if pixels remain.
  - mem_data is captured into the prefetch register exactly MEM_LATENCY cycles after each current_idx change.
  - Any legal parameter set guarantees prefetch is valid before the next load.
- Frame totals:
  - A frame with N pixels holds current_idx ≤ N (never beyond N).
  - busy spans FETCH + N·BITS_PER_PIXEL bit-times + TRESET cycles.
- start_frame while busy is ignored, with no queueing. start_frame held high re-triggers on the cycle after done.
- Arithmetic: the phase counter loads (duration-1) and decrements to 0. The index compare uses the latched length, unsigned.

Optional Feature:
- Macro STRAND_DRIVER_COLOR_ORDER_EN.
- With the macro defined:
  - Adds input color_order[2:0], sampled at frame start.
  - Permutes the three low-order bytes of each word on load:
    - 0 RGB (identity)
    - 1 GRB
    - 2 BRG
    - 3 RBG
    - 4 GBR
    - 5 BGR
    - 6/7 identity
  - With BITS_PER_PIXEL=32, the top byte passes unchanged.
- Without the macro: no port; words are shifted exactly as read.

Test Plan:
- One-wire, length=1, mem_data=24'h800001, MEM_LATENCY=1 → 24 bits, first and last bits high 120 cycles / low 130, others high 50 / low 200; then 5000 low cycles; done pulses once; busy width = 2+24·250+5000.
- Clocked, length=3, RAM={AA5500, 00FF0F, FFFFFF} → 72 clk rising edges, 20-cycle period, data MSB-first matches RAM, no gap cycles at pixel boundaries; current_idx sequence 0, 1, 2, 3.
- strand_length=0 → FETCH skipped, TRESET latch only, done after 5000 cycles, current_idx stays 0.
- start_frame pulsed mid-frame and held high at the end → ignored mid-frame; new frame starts the cycle after done.
- rst asserted during bit 10 of pixel 1 → next cycle all outputs 0, state IDLE, no done; a fresh start_frame runs a full correct frame.
- STRAND_DRIVER_COLOR_ORDER_EN, color_order=1, mem_data=24'h112233 → shifted word 24'h221133; BITS_PER_PIXEL=32 with 32'hAA112233 → 32'hAA221133.
